// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Two-requester (icache / dcache) arbiter in front of a single
//            line-wide data memory. Round-robin on ties, one outstanding
//            transaction at a time, optional watchdog abort with sticky flag.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int TIMEOUT = 255,  // max BUSY cycles without mem_ack_i; 0 = no watchdog
  parameter int TO_W    = 8     // watchdog counter width, TIMEOUT <= 2**TO_W-1
) (
  input  logic         clk_i,
  input  logic         rst_i,        // asynchronous, active-low

  // requester 0 (icache)
  input  logic         m0_enable_i,
  input  logic         m0_write_i,
  input  logic [31:0]  m0_addr_i,
  input  logic [255:0] m0_data_i,
  output logic [255:0] m0_data_o,
  output logic         m0_ack_o,

  // requester 1 (dcache)
  input  logic         m1_enable_i,
  input  logic         m1_write_i,
  input  logic [31:0]  m1_addr_i,
  input  logic [255:0] m1_data_i,
  output logic [255:0] m1_data_o,
  output logic         m1_ack_o,

  // data memory side
  output logic         mem_enable_o,
  output logic         mem_write_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i,

  // status
  output logic [1:0]   grant_o,
  output logic         timeout_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  localparam bit             WD_EN    = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] WD_LIMIT = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0] WD_MAX   = '1;

  state_t          state;
  state_t          state_nx;
  logic            last_grant;     // 0 = m0 served last, 1 = m1 served last
  logic            last_grant_nx;
  logic [TO_W-1:0] count;
  logic [TO_W-1:0] count_nx;
  logic [TO_W-1:0] count_inc;
  logic            timeout_nx;
  logic            wd_hit;
  logic            load0;
  logic            load1;
  logic            busy;

  assign busy = (state == BUSY0) || (state == BUSY1);

  // Saturating increment so a disabled watchdog never wraps back to zero.
  assign count_inc = (count == WD_MAX) ? count : count + 1'b1;

  // The watchdog fires on the BUSY cycle whose increment reaches TIMEOUT.
  assign wd_hit = WD_EN && (count_inc == WD_LIMIT);

  // Next-state, round-robin choice, watchdog and abort bookkeeping.
  always_comb begin
    state_nx      = state;
    last_grant_nx = last_grant;
    count_nx      = count;
    timeout_nx    = timeout_o;
    load0         = 1'b0;
    load1         = 1'b0;

    case (state)
      IDLE: begin
        // m0 wins if alone, or on a tie when m1 was served last.
        if (m0_enable_i && (!m1_enable_i || last_grant)) begin
          state_nx = BUSY0;
          count_nx = '0;
          load0    = 1'b1;
        end else if (m1_enable_i) begin
          state_nx = BUSY1;
          count_nx = '0;
          load1    = 1'b1;
        end
      end

      BUSY0, BUSY1: begin
        // A late ack on the watchdog cycle still completes normally.
        if (mem_ack_i) begin
          state_nx      = IDLE;
          last_grant_nx = (state == BUSY1);
        end else begin
          count_nx = count_inc;
          if (wd_hit) begin
            state_nx      = IDLE;
            timeout_nx    = 1'b1;
            last_grant_nx = (state == BUSY1);
          end
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Control state: FSM, last owner, watchdog counter and sticky abort flag.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      count      <= '0;
      timeout_o  <= 1'b0;
    end else begin
      state      <= state_nx;
      last_grant <= last_grant_nx;
      count      <= count_nx;
      timeout_o  <= timeout_nx;
    end
  end

  // Memory command: enable follows the next state, command fields are captured
  // once at the granting edge and held for the whole transaction.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
    end else begin
      mem_enable_o <= (state_nx != IDLE);
      if (load0) begin
        mem_write_o <= m0_write_i;
        mem_addr_o  <= m0_addr_i;
        mem_data_o  <= m0_data_i;
      end else if (load1) begin
        mem_write_o <= m1_write_i;
        mem_addr_o  <= m1_addr_i;
        mem_data_o  <= m1_data_i;
      end
    end
  end

  // Completion is combinational from mem_ack_i; only the owner sees it, and
  // an ack arriving while IDLE goes nowhere.
  assign m0_ack_o  = busy && (state == BUSY0) && mem_ack_i;
  assign m1_ack_o  = busy && (state == BUSY1) && mem_ack_i;
  assign m0_data_o = m0_ack_o ? mem_data_i : '0;
  assign m1_data_o = m1_ack_o ? mem_data_i : '0;

  assign grant_o   = {state == BUSY1, state == BUSY0};

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Scoreboard bench for mem_arbiter. Instance A uses the default
//            watchdog, instance B uses TIMEOUT = 4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  typedef struct {
    logic         port;
    logic [255:0] data;
  } exp_t;

  logic clk;
  int   checks = 0;
  int   errors = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  // ---------------- instance A signals ----------------
  logic         a_rst_n, a_m0_en, a_m0_wr, a_m1_en, a_m1_wr, a_mem_ack;
  logic [31:0]  a_m0_addr, a_m1_addr;
  logic [255:0] a_m0_wdata, a_m1_wdata, a_mem_rdata;
  logic [255:0] a_m0_rdata, a_m1_rdata, a_mem_wdata;
  logic         a_m0_ack, a_m1_ack, a_mem_en, a_mem_wr, a_timeout;
  logic [31:0]  a_mem_addr;
  logic [1:0]   a_grant;

  // ---------------- instance B signals ----------------
  logic         b_rst_n, b_m0_en, b_mem_ack;
  logic [31:0]  b_m0_addr;
  logic [255:0] b_mem_rdata;
  logic [255:0] b_m0_rdata, b_m1_rdata, b_mem_wdata;
  logic         b_m0_ack, b_m1_ack, b_mem_en, b_mem_wr, b_timeout;
  logic [31:0]  b_mem_addr;
  logic [1:0]   b_grant;
  logic         zero1;
  logic [31:0]  zero32;
  logic [255:0] zero256;

  assign zero1   = 1'b0;
  assign zero32  = '0;
  assign zero256 = '0;

  mem_arbiter dut_a (
    .clk_i(clk), .rst_i(a_rst_n),
    .m0_enable_i(a_m0_en), .m0_write_i(a_m0_wr), .m0_addr_i(a_m0_addr),
    .m0_data_i(a_m0_wdata), .m0_data_o(a_m0_rdata), .m0_ack_o(a_m0_ack),
    .m1_enable_i(a_m1_en), .m1_write_i(a_m1_wr), .m1_addr_i(a_m1_addr),
    .m1_data_i(a_m1_wdata), .m1_data_o(a_m1_rdata), .m1_ack_o(a_m1_ack),
    .mem_enable_o(a_mem_en), .mem_write_o(a_mem_wr), .mem_addr_o(a_mem_addr),
    .mem_data_o(a_mem_wdata), .mem_data_i(a_mem_rdata), .mem_ack_i(a_mem_ack),
    .grant_o(a_grant), .timeout_o(a_timeout)
  );

  mem_arbiter #(.TIMEOUT(4), .TO_W(8)) dut_b (
    .clk_i(clk), .rst_i(b_rst_n),
    .m0_enable_i(b_m0_en), .m0_write_i(zero1), .m0_addr_i(b_m0_addr),
    .m0_data_i(zero256), .m0_data_o(b_m0_rdata), .m0_ack_o(b_m0_ack),
    .m1_enable_i(zero1), .m1_write_i(zero1), .m1_addr_i(zero32),
    .m1_data_i(zero256), .m1_data_o(b_m1_rdata), .m1_ack_o(b_m1_ack),
    .mem_enable_o(b_mem_en), .mem_write_o(b_mem_wr), .mem_addr_o(b_mem_addr),
    .mem_data_o(b_mem_wdata), .mem_data_i(b_mem_rdata), .mem_ack_i(b_mem_ack),
    .grant_o(b_grant), .timeout_o(b_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Bounded wait for instance A to grant someone.
  task automatic wait_grant_a();
    int n;
    n = 0;
    while (a_grant == 2'b00 && n < 20) begin
      tick();
      n++;
    end
    if (a_grant == 2'b00) begin
      checks++;
      errors++;
      $display("FAIL wait_grant_a: grant still %b after %0d cycles, expected a grant", a_grant, n);
    end
  endtask

  // Drive a one-cycle memory ack on instance A, expecting it at requester 'port'.
  task automatic ack_a(input logic port, input logic [255:0] d);
    exp_t e;
    e.port = port;
    e.data = d;
    q_a.push_back(e);
    a_mem_ack   = 1'b1;
    a_mem_rdata = d;
    tick();
    a_mem_ack   = 1'b0;
    a_mem_rdata = '0;
  endtask

  // Monitor for instance A: every ack is popped against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (a_m0_ack || a_m1_ack) begin
      checks++;
      if (q_a.size() == 0) begin
        errors++;
        $display("FAIL a_ack_unexpected: ack0=%b ack1=%b, expected no ack", a_m0_ack, a_m1_ack);
      end else begin
        e = q_a.pop_front();
        if ((a_m0_ack && a_m1_ack) || (a_m1_ack != e.port) ||
            ((e.port ? a_m1_rdata : a_m0_rdata) !== e.data) ||
            ((e.port ? a_m0_rdata : a_m1_rdata) !== '0)) begin
          errors++;
          $display("FAIL a_ack: ack0=%b ack1=%b d0=%0h d1=%0h, expected port %0d data %0h",
                   a_m0_ack, a_m1_ack, a_m0_rdata, a_m1_rdata, e.port, e.data);
        end
      end
    end else begin
      checks++;
      if (a_m0_rdata !== '0 || a_m1_rdata !== '0) begin
        errors++;
        $display("FAIL a_data_idle: d0=%0h d1=%0h, expected 0 without ack", a_m0_rdata, a_m1_rdata);
      end
    end
  end

  // Monitor for instance B.
  always @(negedge clk) begin
    exp_t e;
    if (b_m0_ack || b_m1_ack) begin
      checks++;
      if (q_b.size() == 0) begin
        errors++;
        $display("FAIL b_ack_unexpected: ack0=%b ack1=%b, expected no ack", b_m0_ack, b_m1_ack);
      end else begin
        e = q_b.pop_front();
        if (b_m1_ack || (b_m0_rdata !== e.data)) begin
          errors++;
          $display("FAIL b_ack: ack0=%b ack1=%b d0=%0h, expected port 0 data %0h",
                   b_m0_ack, b_m1_ack, b_m0_rdata, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [1:0]   exp_g;
    logic [255:0] a5;
    exp_t         e;
    a5 = {32{8'hA5}};

    a_rst_n = 1'b0; b_rst_n = 1'b0;
    a_m0_en = 1'b1; a_m1_en = 1'b1;      // both requesting out of reset
    a_m0_wr = 1'b0; a_m1_wr = 1'b0;
    a_m0_addr = 32'h100; a_m1_addr = 32'h200;
    a_m0_wdata = '0; a_m1_wdata = '0;
    a_mem_ack = 1'b0; a_mem_rdata = '0;
    b_m0_en = 1'b0; b_m0_addr = 32'h20; b_mem_ack = 1'b0; b_mem_rdata = '0;

    repeat (2) tick();
    chk("reset_mem_en", a_mem_en, 1'b0);
    chk("reset_grant", a_grant, 2'b00);
    chk("reset_timeout", a_timeout, 1'b0);
    chk("reset_mem_addr", a_mem_addr, 32'h0);
    chk("reset_mem_wr", a_mem_wr, 1'b0);
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;

    // Round-robin with both held: 0,1,0,1, one IDLE cycle between.
    exp_g = 2'b01;
    for (int i = 0; i < 4; i++) begin
      wait_grant_a();
      chk("rr_grant", a_grant, exp_g);
      chk("rr_mem_en", a_mem_en, 1'b1);
      chk("rr_mem_addr", a_mem_addr, exp_g[0] ? 32'h100 : 32'h200);
      ack_a(exp_g[1], {8{32'hC0DE0000 + i}});
      if (i == 3) begin
        a_m0_en = 1'b0;
        a_m1_en = 1'b0;
      end
      chk("rr_idle_grant", a_grant, 2'b00);
      chk("rr_idle_mem_en", a_mem_en, 1'b0);
      exp_g = {exp_g[0], exp_g[1]};
    end
    tick();
    chk("idle_stays", a_grant, 2'b00);

    // m1 read at 0x400, ack after 10 cycles; m1 drops enable mid-BUSY.
    a_m1_wr = 1'b0; a_m1_addr = 32'h0000_0400; a_m1_en = 1'b1;
    tick();
    chk("m1rd_mem_en_latency", a_mem_en, 1'b1);
    chk("m1rd_grant", a_grant, 2'b10);
    chk("m1rd_mem_wr", a_mem_wr, 1'b0);
    chk("m1rd_mem_addr", a_mem_addr, 32'h0000_0400);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 2) a_m1_en = 1'b0;
    end
    chk("m1rd_still_busy", a_grant, 2'b10);
    ack_a(1'b1, a5);
    chk("m1rd_done", a_grant, 2'b00);

    // mem_ack_i while IDLE is ignored.
    a_mem_ack = 1'b1; a_mem_rdata = a5;
    tick(); tick();
    a_mem_ack = 1'b0; a_mem_rdata = '0;
    chk("idle_ack_grant", a_grant, 2'b00);
    chk("idle_ack_mem_en", a_mem_en, 1'b0);

    // m0 write held stable; m1 arrives while m0 is busy and waits.
    a_m0_wr = 1'b1; a_m0_addr = 32'h10; a_m0_wdata = 256'h1234; a_m0_en = 1'b1;
    tick();
    chk("wr_grant", a_grant, 2'b01);
    chk("wr_mem_wr", a_mem_wr, 1'b1);
    chk("wr_mem_addr", a_mem_addr, 32'h10);
    chk("wr_mem_data", a_mem_wdata, 256'h1234);
    a_m0_wr = 1'b0; a_m0_addr = 32'hFFFF_FFF0; a_m0_wdata = '1;
    a_m1_addr = 32'h800; a_m1_en = 1'b1;
    tick(); tick();
    chk("wr_hold_wr", a_mem_wr, 1'b1);
    chk("wr_hold_addr", a_mem_addr, 32'h10);
    chk("wr_hold_data", a_mem_wdata, 256'h1234);
    chk("wr_m1_waits", a_grant, 2'b01);
    a_m0_en = 1'b0;
    ack_a(1'b0, 256'h77);
    chk("wr_gap", a_grant, 2'b00);
    tick();
    chk("waiter_grant", a_grant, 2'b10);
    chk("waiter_addr", a_mem_addr, 32'h800);
    chk("waiter_wr", a_mem_wr, 1'b0);
    a_m1_en = 1'b0;
    ack_a(1'b1, 256'hBEEF);
    chk("waiter_done", a_grant, 2'b00);

    // Reset during BUSY1: immediate clear, no ack, normal restart.
    a_m1_addr = 32'hABC0; a_m1_en = 1'b1;
    tick();
    chk("rst_pre_grant", a_grant, 2'b10);
    tick();
    a_mem_ack = 1'b1; a_mem_rdata = a5;
    a_rst_n = 1'b0;
    #1;
    chk("rst_grant", a_grant, 2'b00);
    chk("rst_mem_en", a_mem_en, 1'b0);
    chk("rst_mem_addr", a_mem_addr, 32'h0);
    chk("rst_no_ack", a_m1_ack, 1'b0);
    tick(); tick();
    a_mem_ack = 1'b0; a_mem_rdata = '0;
    a_rst_n = 1'b1;
    tick();
    chk("rst_regrant", a_grant, 2'b10);
    chk("rst_regrant_en", a_mem_en, 1'b1);
    chk("rst_regrant_addr", a_mem_addr, 32'hABC0);
    a_m1_en = 1'b0;
    ack_a(1'b1, 256'h5A5A);
    chk("rst_done", a_grant, 2'b00);

    // Instance B, TIMEOUT = 4: abort after 4 BUSY cycles, sticky flag.
    b_m0_en = 1'b1;
    tick();
    for (int k = 1; k <= 4; k++) begin
      chk("to_busy", b_grant, 2'b01);
      chk("to_flag_low", b_timeout, 1'b0);
      if (k == 4) b_m0_en = 1'b0;
      tick();
    end
    chk("to_idle", b_grant, 2'b00);
    chk("to_flag_set", b_timeout, 1'b1);
    chk("to_mem_en", b_mem_en, 1'b0);
    tick(); tick();
    chk("to_flag_sticky", b_timeout, 1'b1);

    // Ack on the 4th BUSY cycle wins; twice back-to-back to show the counter
    // restarts for each transaction.
    b_rst_n = 1'b0;
    tick();
    b_rst_n = 1'b1;
    chk("to_flag_cleared", b_timeout, 1'b0);
    for (int r = 0; r < 2; r++) begin
      b_m0_en = 1'b1;
      repeat (4) tick();
      chk("late_ack_busy", b_grant, 2'b01);
      e.port = 1'b0;
      e.data = {8{32'h600D0000 + r}};
      q_b.push_back(e);
      b_mem_ack = 1'b1; b_mem_rdata = e.data; b_m0_en = 1'b0;
      tick();
      b_mem_ack = 1'b0; b_mem_rdata = '0;
      chk("late_ack_idle", b_grant, 2'b00);
      chk("late_ack_no_timeout", b_timeout, 1'b0);
      tick();
    end

    tick(); tick();
    chk("a_queue_empty", q_a.size(), 0);
    chk("b_queue_empty", q_b.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
